por_reset_sequencer: RTL
========================

Name: por_reset_sequencer

Overview:
- Power-on reset sequencer. Converts the asynchronous `power_up` indication into the global active-high `reset` and a set of staggered per-domain resets.
- It is the stage directly upstream of the block governed by the "reset deasserted within 5 cycles of power_up" property. With default parameters it must satisfy `power_up |-> ##[1:5] !reset`.
- It sits between board/PMIC power-good and all downstream reset consumers.

Parameters:
- SYNC_STAGES, 2: depth of the `power_up` synchronizer (≥2).
- HOLD_CYCLES, 2: cycles `reset` is held after FSM enters HOLD (≥1).
- NUM_DOMAINS, 3: number of per-domain reset outputs (≥1).
- STAGGER, 2: cycles between successive domain releases (≥1).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  hard reset. Asynchronous assert, active-low.
- power_up  in  1  raw power-good. Asynchronous to `clk`, level.
- sw_rst_req  in  1  synchronous single-cycle request to re-run the reset sequence.
- reset  out  1  global reset, active-high, registered.
- domain_rst  out  NUM_DOMAINS  per-domain resets, active-high, registered.
- ready  out  1  high when all domains are released.
- state  out  2  FSM state: 0 OFF, 1 HOLD, 2 STAGGER, 3 ON.
- seq_cnt  out  8  saturating count of completed sequences (entries into ON).

Behaviour:
- Reset (`rst_n` low, asynchronous, takes effect without a clock edge):
  - synchronizer flops = 0, `state` = OFF, internal counter = 0.
  - `reset` = 1, `domain_rst` = all 1s, `ready` = 0, `seq_cnt` = 0.
- `power_up` passes through a SYNC_STAGES flop chain; `pu_s` is the last stage. Only `pu_s` is used by the FSM.
- Timing reference: E0 is the first `clk` edge that samples `power_up` = 1; En is n edges later.
- OFF:
  - All outputs in their reset values.
  - `pu_s` = 1 → HOLD and load counter. The transition occurs at E(SYNC_STAGES).
- HOLD:
  - `reset` and all `domain_rst` stay 1.
  - Counter counts HOLD_CYCLES edges.
  - At E(SYNC_STAGES+HOLD_CYCLES), `reset` → 0 and `domain_rst[0]` → 0 in the same edge.
  - If NUM_DOMAINS = 1, go to ON at that edge; otherwise go to STAGGER.
- STAGGER:
  - `domain_rst[i]` deasserts STAGGER edges after `domain_rst[i-1]`.
  - Releases are monotonic from bit 0 upward.
  - The edge that releases bit NUM_DOMAINS-1 → ON.
- ON:
  - `ready` = 1, all resets 0.
  - `seq_cnt` increments on entry and saturates at 255.
- Default latency:
  - `reset` low at E4 (≤5, meets the property).
  - `domain_rst` sequence: 111 → 110 @E4 → 100 @E6 → 000 @E8; `ready` = 1 @E8.
- Power loss (`pu_s` = 0 in any non-OFF state):
  - Next edge: → OFF, `reset` = 1, `domain_rst` = all 1s, `ready` = 0, counter cleared.
  - Latency from the first edge sampling `power_up` = 0 is SYNC_STAGES edges (2 by default).
  - Any low sample visible at `pu_s`, even a single cycle, forces a full restart. No debounce.
- `sw_rst_req` = 1 in HOLD, STAGGER or ON while `pu_s` = 1:
  - Next edge: → HOLD, `reset` and all `domain_rst` = 1, `ready` = 0, counter reloaded.
  - Sequencing then repeats from HOLD; the synchronizer is not re-run.
  - `sw_rst_req` in OFF is ignored.
- Simultaneous `pu_s` = 0 and `sw_rst_req` = 1: power loss wins → OFF.
- Output invariants:
  - `reset` = 0 implies `domain_rst[0]` = 0.
  - `domain_rst[i]` = 0 implies `domain_rst[j]` = 0 for all j<i.
  - `ready` = 1 exactly when `domain_rst` = 0.
- Outputs are glitch-free: flop-driven only, with no combinational path from `power_up` or `sw_rst_req` to any output.
- Counter width: $clog2(max(HOLD_CYCLES,STAGGER)+1). The counter never wraps within a state.

Test Plan:
- `rst_n` low 2 cycles then high; `power_up` = 1 from E0 → `reset` low @E4; `domain_rst` 110 @E4, 100 @E6, 000 @E8; `ready` = 1 @E8; `state` = 3; `seq_cnt` = 1; SVA `power_up |-> ##[1:5] !reset` passes.
- In ON, `power_up` sampled 0 @F0 → @F2 `reset` = 1, `domain_rst` = 111, `ready` = 0, `state` = 0. `power_up` back to 1 → full sequence repeats; `seq_cnt` = 2 at ON.
- In ON, `sw_rst_req` pulse @G0 → @G1 `reset` = 1, `state` = 1; `reset` low @G3; `ready` @G7; `seq_cnt` increments.
- One-cycle `power_up` low glitch during STAGGER (`domain_rst` = 100) → restart from OFF; no domain deasserts out of order; checker on monotonic release holds.
- `rst_n` dropped mid-STAGGER between clock edges → `reset`, `domain_rst`, `ready`, `state` and `seq_cnt` take reset values immediately, with no clock edge required.
- `sw_rst_req` = 1 on the same edge `pu_s` falls → `state` = OFF (not HOLD); `reset` = 1; no release until `power_up` returns.

Source files
------------

// File: rtl/por_reset_sequencer_if.sv
// Reset-sequencer signal bundle: power-good and software request in,
// global/per-domain resets and status out.
interface por_reset_sequencer_if #(
  parameter int unsigned NUM_DOMAINS = 3
);
  logic                   power_up;
  logic                   sw_rst_req;
  logic                   reset;
  logic [NUM_DOMAINS-1:0] domain_rst;
  logic                   ready;
  logic [1:0]             state;
  logic [7:0]             seq_cnt;

  modport master (
    output power_up, sw_rst_req,
    input  reset, domain_rst, ready, state, seq_cnt
  );

  modport slave (
    input  power_up, sw_rst_req,
    output reset, domain_rst, ready, state, seq_cnt
  );
endinterface

// File: rtl/por_reset_sequencer.sv
// Power-on reset sequencer: synchronizes power-good, holds the global reset
// for a fixed time, then releases per-domain resets one at a time from bit 0.
// All outputs come straight from flops.
module por_reset_sequencer #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 2,
  parameter int unsigned NUM_DOMAINS = 3,
  parameter int unsigned STAGGER     = 2
) (
  input logic                clk,
  input logic                rst_n,
  por_reset_sequencer_if.slave bus
);

  localparam int unsigned CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0]          HOLD_LD  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0]          STAG_LD  = CW'(STAGGER - 1);
  localparam logic [NUM_DOMAINS-1:0] DOM_ONES = '1;

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_HOLD    = 2'd1,
    ST_STAGGER = 2'd2,
    ST_ON      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pu_s;

  state_t                 state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   reset_q, reset_d;
  logic [NUM_DOMAINS-1:0] dom_q, dom_d;
  logic                   ready_q, ready_d;
  logic [7:0]             seq_q, seq_d;

  // power_up synchronizer chain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], bus.power_up};
  end

  assign pu_s = sync_q[SYNC_STAGES-1];

  // FSM state, counter and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_OFF;
      cnt_q   <= '0;
      reset_q <= 1'b1;
      dom_q   <= '1;
      ready_q <= 1'b0;
      seq_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      reset_q <= reset_d;
      dom_q   <= dom_d;
      ready_q <= ready_d;
      seq_q   <= seq_d;
    end
  end

  // Next-state and next-output logic; power loss outranks software request.
  // Domains release by shifting zeros in from bit 0, so an all-zero result
  // marks the final release (this also covers NUM_DOMAINS = 1 from HOLD).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    reset_d = reset_q;
    dom_d   = dom_q;
    if (!pu_s) begin
      state_d = ST_OFF;
      cnt_d   = '0;
      reset_d = 1'b1;
      dom_d   = '1;
    end else if (bus.sw_rst_req && (state_q != ST_OFF)) begin
      state_d = ST_HOLD;
      cnt_d   = HOLD_LD;
      reset_d = 1'b1;
      dom_d   = '1;
    end else begin
      case (state_q)
        ST_OFF: begin
          state_d = ST_HOLD;
          cnt_d   = HOLD_LD;
        end
        ST_HOLD: begin
          if (cnt_q == '0) begin
            reset_d = 1'b0;
            dom_d   = DOM_ONES << 1;
            if (dom_d == '0) begin
              state_d = ST_ON;
              cnt_d   = '0;
            end else begin
              state_d = ST_STAGGER;
              cnt_d   = STAG_LD;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        ST_STAGGER: begin
          if (cnt_q == '0) begin
            dom_d = dom_q << 1;
            if (dom_d == '0) begin
              state_d = ST_ON;
              cnt_d   = '0;
            end else begin
              cnt_d = STAG_LD;
            end
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Ready and saturating sequence counter derive from the next values
  always_comb begin
    ready_d = (dom_d == '0);
    seq_d   = seq_q;
    if ((state_d == ST_ON) && (state_q != ST_ON) && (seq_q != 8'hFF))
      seq_d = seq_q + 8'd1;
  end

  assign bus.reset      = reset_q;
  assign bus.domain_rst = dom_q;
  assign bus.ready      = ready_q;
  assign bus.state      = state_q;
  assign bus.seq_cnt    = seq_q;

endmodule
